// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates one single-port video RAM between a display reader
// (strict priority) and two round-robin game-logic writers. Transactions are
// driven on mem_* from registers in the cycle after the arbitration edge.
// Optional macro VRAM_BLANK_WR_EN: writers only eligible during blanking.
module vram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned H_ACT  = 640,
  parameter int unsigned V_ACT  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        p_x,
  input  logic [9:0]        p_y,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR0, WR1} state_t;

  state_t              state, state_n;
  logic                rr, rr_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic                we_n, gnt0_n, gnt1_n, valid_n;
  logic                active, wr_ok, elig0, elig1;

  // Scan position inside the visible area
  assign active = (p_x < 10'(H_ACT)) && (p_y < 10'(V_ACT));

`ifdef VRAM_BLANK_WR_EN
  assign wr_ok = !active;
`else
  logic unused_active;
  assign unused_active = active;
  assign wr_ok = 1'b1;
`endif

  // A writer granted last edge still shows its stale request this edge
  assign elig0 = wr0_req && wr_ok && (state != WR0);
  assign elig1 = wr1_req && wr_ok && (state != WR1);

  // Read data is the RAM output during the cycle after the RD cycle
  assign disp_rdata = disp_valid ? mem_rdata : '0;

  // Next-state arbitration and next values of the registered RAM-side outputs
  always_comb begin
    state_n = IDLE;
    rr_n    = rr;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    we_n    = 1'b0;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    valid_n = (state == RD);
    if (disp_req) begin
      state_n = RD;
      addr_n  = disp_addr;
    end else if (elig0 && (!elig1 || !rr)) begin
      state_n = WR0;
      addr_n  = wr0_addr;
      wdata_n = wr0_data;
      we_n    = 1'b1;
      gnt0_n  = 1'b1;
      rr_n    = 1'b1;
    end else if (elig1) begin
      state_n = WR1;
      addr_n  = wr1_addr;
      wdata_n = wr1_data;
      we_n    = 1'b1;
      gnt1_n  = 1'b1;
      rr_n    = 1'b0;
    end
  end

  // State, round-robin pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      wr0_gnt    <= 1'b0;
      wr1_gnt    <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      rr         <= rr_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
      mem_we     <= we_n;
      wr0_gnt    <= gnt0_n;
      wr1_gnt    <= gnt1_n;
      disp_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table vectors, hand-written corner sequences and random
// traffic checked against a transaction-level reference model.
module tb_vram_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    p_x, p_y;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_valid;
  logic          wr0_req, wr1_req, wr0_gnt, wr1_gnt;
  logic [AW-1:0] wr0_addr, wr1_addr, mem_addr;
  logic [DW-1:0] wr0_data, wr1_data, mem_wdata, mem_rdata;
  logic          mem_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .p_x(p_x), .p_y(p_y),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_valid(disp_valid),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM, read-first, one cycle read latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: expected RAM-side outputs for the cycle after each edge
  logic [DW-1:0] model_ram [0:(1<<AW)-1];
  logic          m_we = 0, m_g0 = 0, m_g1 = 0, m_valid = 0, m_read = 0, m_pref = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0, m_rdata = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 'h123) ? 8'h5A : 8'(a * 7 + 3);
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] <= init_val(i);
      model_ram[i] = init_val(i);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_update();
    logic bok, e0, e1, take0;
    logic [DW-1:0] rd;
    if (m_we) model_ram[m_addr] = m_wdata;
    rd = model_ram[m_addr];
`ifdef VRAM_BLANK_WR_EN
    bok = !((int'(p_x) < 640) && (int'(p_y) < 480));
`else
    bok = 1'b1;
`endif
    e0 = wr0_req && bok && !m_g0;
    e1 = wr1_req && bok && !m_g1;
    if (rst) begin
      m_we = 0; m_g0 = 0; m_g1 = 0; m_valid = 0; m_rdata = 0;
      m_read = 0; m_pref = 0; m_addr = 0; m_wdata = 0;
    end else begin
      m_valid = m_read;
      m_rdata = m_read ? rd : 8'h00;
      m_we = 0; m_g0 = 0; m_g1 = 0; m_read = 0;
      if (disp_req) begin
        m_read = 1; m_addr = disp_addr;
      end else if (e0 || e1) begin
        take0 = e0 && e1 ? (m_pref == 0) : e0;
        m_we = 1;
        if (take0) begin
          m_g0 = 1; m_addr = wr0_addr; m_wdata = wr0_data; m_pref = 1;
        end else begin
          m_g1 = 1; m_addr = wr1_addr; m_wdata = wr1_data; m_pref = 0;
        end
      end
    end
  endtask

  task automatic model_compare();
    chk("model_we", 32'(mem_we), 32'(m_we));
    chk("model_addr", 32'(mem_addr), 32'(m_addr));
    chk("model_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("model_gnt0", 32'(wr0_gnt), 32'(m_g0));
    chk("model_gnt1", 32'(wr1_gnt), 32'(m_g1));
    chk("model_valid", 32'(disp_valid), 32'(m_valid));
    if (m_valid) chk("model_rdata", 32'(disp_rdata), 32'(m_rdata));
  endtask

  // One clock edge: model follows the sampled inputs, outputs checked after it
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    model_compare();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; disp_req = 0; disp_addr = 0;
    wr0_req = 0; wr0_addr = 0; wr0_data = 0;
    wr1_req = 0; wr1_addr = 0; wr1_data = 0;
  endtask

  task automatic reset_cycle();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic          rst, dreq;
    logic [AW-1:0] daddr;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic          eg0, eg1, ev;
    logic [DW-1:0] erd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, dq, input logic [AW-1:0] da,
    input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic ewe, input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
    input logic eg0, eg1, ev, input logic [DW-1:0] erd);
    vec_t v;
    v.rst = r; v.dreq = dq; v.daddr = da;
    v.w0 = w0; v.a0 = a0; v.d0 = d0; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.eg0 = eg0; v.eg1 = eg1; v.ev = ev; v.erd = erd;
    return v;
  endfunction

  initial begin
    vec_t tv[16];
    logic prev_g0, prev_g1, done0, done1;
    int   tmo;

    idle_inputs();
    p_x = 10'd700; p_y = 10'd100;

    //        rst dq daddr   w0 a0     d0     w1 a1     d1     we addr   wdata  g0 g1 v  rdata
    tv[0]  = mk(1, 0, 13'h000, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h000, 8'h00, 0, 0, 0, 8'h00);
    tv[1]  = mk(0, 1, 13'h123, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h123, 8'h00, 0, 0, 0, 8'h00);
    tv[2]  = mk(0, 0, 13'h000, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h123, 8'h00, 0, 0, 1, 8'h5A);
    tv[3]  = mk(0, 0, 13'h000, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h123, 8'h00, 0, 0, 0, 8'h00);
    tv[4]  = mk(0, 0, 13'h000, 0, 13'h00, 8'h00, 1, 13'h10, 8'hA5, 1, 13'h010, 8'hA5, 0, 1, 0, 8'h00);
    tv[5]  = mk(0, 0, 13'h000, 0, 13'h00, 8'h00, 1, 13'h10, 8'hA5, 0, 13'h010, 8'hA5, 0, 0, 0, 8'h00);
    tv[6]  = mk(0, 1, 13'h010, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h010, 8'hA5, 0, 0, 0, 8'h00);
    tv[7]  = mk(0, 0, 13'h000, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h010, 8'hA5, 0, 0, 1, 8'hA5);
    tv[8]  = mk(0, 0, 13'h000, 1, 13'h20, 8'h11, 1, 13'h21, 8'h22, 1, 13'h020, 8'h11, 1, 0, 0, 8'h00);
    tv[9]  = mk(0, 0, 13'h000, 1, 13'h20, 8'h11, 1, 13'h21, 8'h22, 1, 13'h021, 8'h22, 0, 1, 0, 8'h00);
    tv[10] = mk(0, 0, 13'h000, 1, 13'h30, 8'h33, 1, 13'h21, 8'h22, 1, 13'h030, 8'h33, 1, 0, 0, 8'h00);
    tv[11] = mk(0, 1, 13'h020, 1, 13'h30, 8'h33, 0, 13'h00, 8'h00, 0, 13'h020, 8'h33, 0, 0, 0, 8'h00);
    tv[12] = mk(0, 1, 13'h021, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h021, 8'h33, 0, 0, 1, 8'h11);
    tv[13] = mk(0, 1, 13'h030, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h030, 8'h33, 0, 0, 1, 8'h22);
    tv[14] = mk(1, 1, 13'h031, 0, 13'h00, 8'h00, 0, 13'h00, 8'h00, 0, 13'h000, 8'h00, 0, 0, 0, 8'h00);
    tv[15] = mk(0, 0, 13'h000, 1, 13'h40, 8'h44, 1, 13'h41, 8'h55, 1, 13'h040, 8'h44, 1, 0, 0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      rst = tv[i].rst; disp_req = tv[i].dreq; disp_addr = tv[i].daddr;
      wr0_req = tv[i].w0; wr0_addr = tv[i].a0; wr0_data = tv[i].d0;
      wr1_req = tv[i].w1; wr1_addr = tv[i].a1; wr1_data = tv[i].d1;
      tick();
      chk($sformatf("row%0d_we", i), 32'(mem_we), 32'(tv[i].ewe));
      chk($sformatf("row%0d_addr", i), 32'(mem_addr), 32'(tv[i].eaddr));
      chk($sformatf("row%0d_wdata", i), 32'(mem_wdata), 32'(tv[i].ewd));
      chk($sformatf("row%0d_gnt0", i), 32'(wr0_gnt), 32'(tv[i].eg0));
      chk($sformatf("row%0d_gnt1", i), 32'(wr1_gnt), 32'(tv[i].eg1));
      chk($sformatf("row%0d_valid", i), 32'(disp_valid), 32'(tv[i].ev));
      if (tv[i].ev || tv[i].rst)
        chk($sformatf("row%0d_rdata", i), 32'(disp_rdata), 32'(tv[i].erd));
    end

    // Both writers held high: grants alternate starting with writer 0
    reset_cycle();
    wr0_req = 1; wr0_addr = 13'h50; wr0_data = 8'h0F;
    wr1_req = 1; wr1_addr = 13'h51; wr1_data = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("alt_gnt0", 32'(wr0_gnt), 32'(i % 2 == 0));
      chk("alt_gnt1", 32'(wr1_gnt), 32'(i % 2 == 1));
    end

    // Writer starved by 20 cycles of display reads, granted right after
    reset_cycle();
    wr0_req = 1; wr0_addr = 13'h52; wr0_data = 8'h77;
    disp_req = 1; disp_addr = 13'h200;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("starve_no_gnt0", 32'(wr0_gnt), 32'd0);
    end
    disp_req = 0;
    tick();
    chk("starve_then_gnt0", 32'(wr0_gnt), 32'd1);
    wr0_req = 0;
    tick();

    // Reset during a stream of reads cuts the in-flight read
    reset_cycle();
    for (int i = 0; i < 4; i++) begin
      disp_req = 1; disp_addr = 13'(13'h100 + i);
      tick();
    end
    rst = 1; disp_addr = 13'h104;
    tick();
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_rdata", 32'(disp_rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    rst = 0; disp_addr = 13'h105;
    tick();
    chk("rst_cut_read", 32'(disp_valid), 32'd0);
    chk("rst_rearb_addr", 32'(mem_addr), 32'h105);
    disp_req = 0;
    tick();
    chk("rst_resume_valid", 32'(disp_valid), 32'd1);
    chk("rst_resume_rdata", 32'(disp_rdata), 32'(init_val('h105)));

`ifdef VRAM_BLANK_WR_EN
    // Writes held off while the beam is in the visible area
    reset_cycle();
    p_x = 10'd100; p_y = 10'd100;
    wr0_req = 1; wr0_addr = 13'h60; wr0_data = 8'h66;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blank_no_gnt0", 32'(wr0_gnt), 32'd0);
    end
    p_x = 10'd650;
    tmo = 0;
    tick();
    chk("blank_gnt0", 32'(wr0_gnt), 32'd1);
    wr0_req = 0;
    tick();
    p_x = 10'd700;
`endif

    // Random traffic against the reference model
    reset_cycle();
    prev_g0 = 0; prev_g1 = 0; done0 = 0; done1 = 0; tmo = 0;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      disp_req  = ($urandom_range(0, 9) < 4);
      disp_addr = 13'($urandom_range(0, 15));
      p_x       = 10'($urandom_range(0, 799));
      p_y       = 10'($urandom_range(0, 524));
      if (done0) begin
        done0 = 0; wr0_req = 1'($urandom_range(0, 1));
        wr0_addr = 13'($urandom_range(0, 15)); wr0_data = 8'($urandom);
      end else if (m_g0) done0 = 1;
      else if (!wr0_req) begin
        wr0_req = 1'($urandom_range(0, 1));
        wr0_addr = 13'($urandom_range(0, 15)); wr0_data = 8'($urandom);
      end
      if (done1) begin
        done1 = 0; wr1_req = 1'($urandom_range(0, 1));
        wr1_addr = 13'($urandom_range(0, 15)); wr1_data = 8'($urandom);
      end else if (m_g1) done1 = 1;
      else if (!wr1_req) begin
        wr1_req = 1'($urandom_range(0, 1));
        wr1_addr = 13'($urandom_range(0, 15)); wr1_data = 8'($urandom);
      end
      tick();
      chk("no_repeat_gnt0", 32'(wr0_gnt & prev_g0), 32'd0);
      chk("no_repeat_gnt1", 32'(wr1_gnt & prev_g1), 32'd0);
      prev_g0 = wr0_gnt;
      prev_g1 = wr1_gnt;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, sets video RAM address width (80x60 tile map).
REQ-002 Parameter DATA_W, default 8, sets video RAM data width.
REQ-003 Parameter H_ACT, default 640, is the active pixels per line.
REQ-004 Parameter V_ACT, default 480, is the active lines per frame.
REQ-005 Port clk  in  1  is the single clock; every register SHALL update on its rising edge.
REQ-006 Port rst  in  1  is the reset, synchronous and active-high.
REQ-007 Port p_x, p_y  in  10 each  are the current scan position from the VGA sync block.
REQ-008 Port disp_req  in  1, disp_addr  in  ADDR_W  carry a display read request and its address.
REQ-009 Port disp_rdata  out  DATA_W, disp_valid  out  1  return read data as a one-cycle pulse.
REQ-010 Ports wr0_req in 1, wr0_addr in ADDR_W, wr0_data in DATA_W, wr0_gnt out 1  form game-logic writer 0.
REQ-011 Ports wr1_req, wr1_addr, wr1_data, wr1_gnt  (same widths)  form game-logic writer 1.
REQ-012 Ports mem_addr out ADDR_W, mem_we out 1, mem_wdata out DATA_W, mem_rdata in DATA_W  drive single-port RAM (1-cycle read latency).

Function
REQ-013 Arbitration SHALL be evaluated at every clk edge; the winner's transaction SHALL be driven on mem_* from registers during the following cycle.
REQ-014 FSM states IDLE, RD, WR0, WR1 SHALL name the transaction occupying the RAM in the current cycle; next state = arbitration winner, IDLE if none.
REQ-015 disp_req SHALL have strict priority over both writers in every cycle.
REQ-016 Writers SHALL be served round-robin: pointer rr selects the preferred writer; after a grant to writer k, rr SHALL point to the other writer.
REQ-017 A writer granted at edge N SHALL be ineligible at edge N+1 (its req is still stale then); it may win again at N+2.
REQ-018 In state WRk: mem_we=1, mem_addr=wrk_addr, mem_wdata=wrk_data as sampled, and wrk_gnt=1 for exactly that cycle.
REQ-019 Writers SHALL hold req/addr/data stable until gnt is seen; they drop req or present the next transaction the cycle after gnt.
REQ-020 Read latency: disp_req sampled at edge N -> RD in cycle N+1 with mem_addr=disp_addr, mem_we=0 -> disp_rdata=mem_rdata, disp_valid=1 in cycle N+2 only.
REQ-021 Back-to-back disp_req SHALL produce back-to-back disp_valid pulses, one per request, in order.
REQ-022 In IDLE: mem_we=0, both gnt=0, mem_addr and mem_wdata hold their last values.
REQ-023 active = (p_x < H_ACT) && (p_y < V_ACT), evaluated combinationally from p_x/p_y at the arbitration edge.
REQ-024 Simultaneous wr0_req and wr1_req with no disp_req: grant goes to rr; the other waits at least one cycle.
REQ-025 A writer continuously starved by disp_req SHALL remain pending with no grant and no loss of its request.

Reset
REQ-026 On rst sampled high: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, wr0_gnt=wr1_gnt=0, disp_valid=0, disp_rdata=0, rr=0 (writer 0 preferred), all in the following cycle.
REQ-027 A transaction occupying the RAM in the cycle rst is sampled SHALL complete; a read issued that cycle SHALL NOT produce disp_valid; requests present during rst SHALL be ignored and re-arbitrated after release.

Configuration
REQ-028 Macro VRAM_BLANK_WR_EN defined: writers are eligible only when active=0 (blanking), regardless of disp_req.
REQ-029 Macro VRAM_BLANK_WR_EN undefined: writers are eligible in any cycle in which disp_req=0.

Verification
REQ-030 disp_req=1 addr 0x0123 at edge N, RAM holds 0x5A there -> mem_addr=0x0123, mem_we=0 in N+1; disp_rdata=0x5A, disp_valid=1 in N+2 only.
REQ-031 wr0_req and wr1_req held high continuously, disp_req=0, p_x=700 -> grants alternate wr0,wr1,wr0,...; no writer is granted on two consecutive cycles.
REQ-032 Only wr1_req high (addr 0x0010, data 0xA5), held until gnt -> exactly one cycle with mem_we=1, mem_addr=0x0010, mem_wdata=0xA5, wr1_gnt=1.
REQ-033 disp_req high for 20 cycles with wr0_req high -> no wr0_gnt during that span; wr0_gnt in the cycle after the first arbitration edge with disp_req=0.
REQ-034 VRAM_BLANK_WR_EN defined, wr0_req high, disp_req=0, p_x=100/p_y=100 -> no grant; p_x changed to 650 -> wr0_gnt one cycle later.
REQ-035 rst asserted one cycle during a stream of reads -> all outputs 0 next cycle, no disp_valid for the cut read, rr=0, normal arbitration after release.
